// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V control FSM: FETCH/DECODE/EXEC/MEM/WB over a variable-latency memory port,
// with illegal-opcode and bus-timeout traps, HALT, and a retired-instruction counter.
module multicycle_controller #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       Opcode,
  input  logic             mem_ready,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             ALUSrc,
  output logic [1:0]       ALUOp,
  output logic             Branch,
  output logic             JalrSel,
  output logic             JmpSel,
  output logic             halted,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
    S_WB    = 3'd4, S_HALT   = 3'd5, S_TRAP = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_I, C_U, C_LW, C_SW, C_BR, C_JAL, C_JALR, C_HALT, C_ILL
  } cls_t;

  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] TO_LIM = WAIT_W'(TIMEOUT);
  localparam logic              TO_EN  = (TIMEOUT != 0);

  state_t             state_q, state_d;
  cls_t               cls_q, cls_d;
  logic [1:0]         cause_q, cause_d;
  logic [WAIT_W-1:0]  wait_q, wait_d, wait_nxt;
  logic [CNT_W-1:0]   instret_q;
  logic               timeout_hit;

  function automatic cls_t decode_op(input logic [6:0] op);
    case (op)
      7'b0110011: decode_op = C_R;
      7'b0010011: decode_op = C_I;
      7'b0110111: decode_op = C_U;
      7'b0000011: decode_op = C_LW;
      7'b0100011: decode_op = C_SW;
      7'b1100011: decode_op = C_BR;
      7'b1101111: decode_op = C_JAL;
      7'b1100111: decode_op = C_JALR;
      7'b0000001: decode_op = C_HALT;
      default:    decode_op = C_ILL;
    endcase
  endfunction

  // The limit cycle traps only if mem_ready is still low; a completing access wins.
  assign wait_nxt    = wait_q + WAIT_W'(1);
  assign timeout_hit = TO_EN && !mem_ready && (wait_nxt == TO_LIM);

  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    cause_d  = cause_q;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = 2'b00;
    Branch   = 1'b0;
    JalrSel  = 1'b0;
    JmpSel   = 1'b0;

    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      ALUSrc  = (cls_q == C_LW) || (cls_q == C_SW) || (cls_q == C_I) || (cls_q == C_U);
      Branch  = (cls_q == C_BR);
      JalrSel = (cls_q == C_JALR);
      JmpSel  = (cls_q == C_JAL) || (cls_q == C_JALR);
      case (cls_q)
        C_BR:       ALUOp = 2'b01;
        C_R, C_I:   ALUOp = 2'b10;
        C_U:        ALUOp = 2'b11;
        default:    ALUOp = 2'b00;
      endcase
    end

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_DECODE: begin
        cls_d = decode_op(Opcode);
        if (cls_d == C_HALT) begin
          state_d = S_HALT;
        end else if (cls_d == C_ILL) begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cls_q == C_LW || cls_q == C_SW) begin
          state_d = S_MEM;
        end else if (cls_q == C_BR) begin
          PCWrite = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        IorD     = 1'b1;
        MemRead  = (cls_q == C_LW);
        MemWrite = (cls_q == C_SW);
        if (mem_ready) begin
          if (cls_q == C_SW) begin
            PCWrite = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        MemtoReg = (cls_q == C_LW);
        state_d  = S_FETCH;
      end
      S_HALT, S_TRAP: ;
      default: state_d = S_FETCH;
    endcase

    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready) begin
      wait_d = wait_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cls_q     <= C_R;
      cause_q   <= 2'b00;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      cause_q   <= cause_d;
      wait_q    <= wait_d;
      instret_q <= instret_q + CNT_W'(PCWrite);
    end
  end

  assign halted     = (state_q == S_HALT);
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;
  assign instret    = instret_q;
  assign state      = state_q;

endmodule
